// File: rtl/servo_em_if.sv
// servo_em_if: command handshake between the station FSM and the servo/EM sequencer
//   cmd_valid/cmd_op : master -> slave command (01 PICKUP, 10 DROP, 00/11 reserved)
//   cmd_ready        : slave  -> master, high only while the sequencer is idle
//   done/err         : slave  -> master completion pulse, err marks a rejected command
interface servo_em_if;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready;
  logic       done;
  logic       err;
  modport master (output cmd_valid, cmd_op, input cmd_ready, done, err);
  modport slave (input cmd_valid, cmd_op, output cmd_ready, done, err);
endinterface

// File: rtl/servo_em_sequencer.sv
// servo_em_sequencer: times servo arm travel, drives the electromagnet and generates the 50 Hz servo PWM
//   clk, rst   : clock, synchronous active-high reset
//   cmd        : command handshake (servo_em_if slave)
//   busy       : high in every state except idle
//   holding    : washer held after a completed pickup
//   arm_down   : commanded servo target, 1 = down
//   control_em : electromagnet drive
//   servo_pwm  : registered servo pulse train
module servo_em_sequencer #(
  parameter int unsigned PWM_PERIOD = 2000000,
  parameter int unsigned PW_UP      = 100000,
  parameter int unsigned PW_DOWN    = 200000,
  parameter int unsigned SETTLE_CYC = 50000000,
  parameter int unsigned GRIP_CYC   = 20000000
) (
  input  logic        clk,
  input  logic        rst,
  servo_em_if.slave   cmd,
  output logic        busy,
  output logic        holding,
  output logic        arm_down,
  output logic        control_em,
  output logic        servo_pwm
);
  typedef enum logic [2:0] {IDLE, LOWER, ENGAGE, RELEASE, RAISE, DONE, REJECT} state_t;
  state_t      state_q, state_d;
  logic [31:0] timer_q, timer_d, cnt_q, cnt_d, width_q, width_d;
  logic        pick_q, pick_d;
  logic        cmd_ready_q, cmd_ready_d, done_q, done_d, err_q, err_d, busy_q, busy_d;
  logic        holding_q, holding_d, arm_down_q, arm_down_d, control_em_q, control_em_d;
  logic        servo_pwm_q, servo_pwm_d;
  logic        accept, legal, tz, frame_end;
  assign accept    = cmd.cmd_valid & cmd_ready_q;
  assign legal     = (cmd.cmd_op == 2'b01 && !holding_q) || (cmd.cmd_op == 2'b10 && holding_q);
  assign tz        = timer_q == '0;
  assign frame_end = cnt_q == PWM_PERIOD - 1;
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pick_d  = pick_q;
    case (state_q)
      IDLE: if (accept) begin
        pick_d  = cmd.cmd_op == 2'b01;
        state_d = legal ? LOWER : REJECT;
        timer_d = legal ? SETTLE_CYC - 1 : timer_q;
      end
      LOWER: begin
        state_d = tz ? (pick_q ? ENGAGE : RELEASE) : LOWER;
        timer_d = tz ? GRIP_CYC - 1 : timer_q - 32'd1;
      end
      ENGAGE, RELEASE: begin
        state_d = tz ? RAISE : state_q;
        timer_d = tz ? SETTLE_CYC - 1 : timer_q - 32'd1;
      end
      RAISE: begin
        state_d = tz ? DONE : RAISE;
        timer_d = tz ? timer_q : timer_q - 32'd1;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are derived from the next state so they are registered alongside it.
    cmd_ready_d  = state_d == IDLE;
    busy_d       = state_d != IDLE;
    done_d       = state_d == DONE || state_d == REJECT;
    err_d        = state_d == REJECT;
    arm_down_d   = state_d == LOWER || state_d == ENGAGE || state_d == RELEASE;
    control_em_d = state_d == ENGAGE ? 1'b1 : state_d == RELEASE ? 1'b0 : control_em_q;
    holding_d    = state_d == DONE ? pick_q : holding_q;
    // Width is only re-latched at frame end so a mid-frame target change never truncates a pulse.
    cnt_d        = frame_end ? '0 : cnt_q + 32'd1;
    width_d      = frame_end ? (arm_down_q ? PW_DOWN : PW_UP) : width_q;
    servo_pwm_d  = cnt_q < width_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      pick_q       <= 1'b0;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      arm_down_q   <= 1'b0;
      control_em_q <= 1'b0;
      holding_q    <= 1'b0;
      cnt_q        <= '0;
      width_q      <= PW_UP;
      servo_pwm_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      pick_q       <= pick_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      arm_down_q   <= arm_down_d;
      control_em_q <= control_em_d;
      holding_q    <= holding_d;
      cnt_q        <= cnt_d;
      width_q      <= width_d;
      servo_pwm_q  <= servo_pwm_d;
    end
  end
  assign cmd.cmd_ready = cmd_ready_q;
  assign cmd.done      = done_q;
  assign cmd.err       = err_q;
  assign busy          = busy_q;
  assign holding       = holding_q;
  assign arm_down      = arm_down_q;
  assign control_em    = control_em_q;
  assign servo_pwm     = servo_pwm_q;
endmodule

// File: tb/tb_servo_em_sequencer.sv
// tb_servo_em_sequencer: directed stimulus with a done/err scoreboard for servo_em_sequencer
module tb_servo_em_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, holding, arm_down, control_em, servo_pwm;
  int checks = 0;
  int failures = 0;
  typedef struct {time t; bit err; bit hold; bit em;} exp_t;
  exp_t sb[$];
  servo_em_if cif();
  servo_em_sequencer #(.PWM_PERIOD(20), .PW_UP(2), .PW_DOWN(4), .SETTLE_CYC(4), .GRIP_CYC(3)) dut (
    .clk(clk), .rst(rst), .cmd(cif.slave), .busy(busy), .holding(holding),
    .arm_down(arm_down), .control_em(control_em), .servo_pwm(servo_pwm)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask
  // Scoreboard monitor: every done/err pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (!rst && (cif.done || cif.err)) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done done=%0b err=%0b at %0t required=no pulse", cif.done, cif.err, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (!(cif.done && cif.err == e.err && holding == e.hold && control_em == e.em && $time == e.t)) begin
          failures++;
          $display("FAIL done_pulse actual t=%0t done=%0b err=%0b hold=%0b em=%0b required t=%0t done=1 err=%0b hold=%0b em=%0b",
                   $time, cif.done, cif.err, holding, control_em, e.t, e.err, e.hold, e.em);
        end
      end
    end
  end
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!cif.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(cif.cmd_ready), 1);
  endtask
  // Rejected command: done/err land in cycle 1, nothing else moves.
  task automatic reject(input logic [1:0] op, input bit hold, input bit em);
    time t;
    wait_ready();
    cif.cmd_valid = 1'b1;
    cif.cmd_op = op;
    @(posedge clk);
    t = $time;
    sb.push_back('{t + 5, 1'b1, hold, em});
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    chk("rej_busy", 32'(busy), 1);
    chk("rej_ready", 32'(cif.cmd_ready), 0);
    chk("rej_arm", 32'(arm_down), 0);
    @(negedge clk);
    chk("rej_ready_back", 32'(cif.cmd_ready), 1);
  endtask
  // Accepted command aligned so the accept edge closes cycle P+15, P being the first
  // high cycle of a PWM frame; the next frame boundary then falls while the arm is down.
  task automatic traced(input logic [1:0] op, input bit pick);
    time t;
    int n = 0;
    @(negedge clk);
    while (servo_pwm && n < 100) begin @(negedge clk); n++; end
    while (!servo_pwm && n < 100) begin @(negedge clk); n++; end
    chk("pwm_align", 32'(servo_pwm), 1);
    repeat (15) @(negedge clk);
    cif.cmd_valid = 1'b1;
    cif.cmd_op = op;
    @(posedge clk);
    t = $time;
    sb.push_back('{t + 115, 1'b0, pick, pick});
    for (int k = 1; k <= 27; k++) begin
      @(negedge clk);
      if (k == 1) cif.cmd_valid = 1'b0;
      chk($sformatf("arm_c%0d", k), 32'(arm_down), 32'(k <= 7));
      chk($sformatf("em_c%0d", k), 32'(control_em), 32'(k >= 5 ? pick : !pick));
      chk($sformatf("ready_c%0d", k), 32'(cif.cmd_ready), 32'(k >= 13));
      chk($sformatf("busy_c%0d", k), 32'(busy), 32'(k <= 12));
      if (k >= 5 && k <= 9) chk($sformatf("pwm_wide_c%0d", k), 32'(servo_pwm), 32'(k <= 8));
      if (k >= 25) chk($sformatf("pwm_narrow_c%0d", k), 32'(servo_pwm), 32'(k <= 26));
    end
    chk("hold_after", 32'(holding), 32'(pick));
  endtask
  initial begin
    time t;
    int hi;
    cif.cmd_valid = 1'b0;
    cif.cmd_op = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(cif.cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(cif.done), 0);
    chk("rst_err", 32'(cif.err), 0);
    chk("rst_hold", 32'(holding), 0);
    chk("rst_arm", 32'(arm_down), 0);
    chk("rst_em", 32'(control_em), 0);
    chk("rst_pwm", 32'(servo_pwm), 0);
    rst = 1'b0;
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      hi += int'(servo_pwm);
      if (i == 19) chk("pwm_frame1_high", 32'(hi), 2);
    end
    chk("pwm_40_high", 32'(hi), 4);
    chk("idle_ready", 32'(cif.cmd_ready), 1);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_em", 32'(control_em), 0);
    reject(2'b10, 1'b0, 1'b0);
    reject(2'b11, 1'b0, 1'b0);
    reject(2'b00, 1'b0, 1'b0);
    traced(2'b01, 1'b1);
    reject(2'b01, 1'b1, 1'b1);
    reject(2'b11, 1'b1, 1'b1);
    traced(2'b10, 1'b0);
    // Valid held across both commands: second accept on the idle cycle right after done.
    wait_ready();
    cif.cmd_valid = 1'b1;
    cif.cmd_op = 2'b01;
    @(posedge clk);
    t = $time;
    sb.push_back('{t + 115, 1'b0, 1'b1, 1'b1});
    sb.push_back('{t + 245, 1'b0, 1'b0, 1'b0});
    repeat (12) @(negedge clk);
    cif.cmd_op = 2'b10;
    @(negedge clk);
    chk("cont_idle_ready", 32'(cif.cmd_ready), 1);
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    chk("cont_second_busy", 32'(busy), 1);
    chk("cont_second_arm", 32'(arm_down), 1);
    repeat (14) @(negedge clk);
    chk("cont_hold", 32'(holding), 0);
    // Reset asserted during cycle 6 of a pickup aborts it with no done pulse.
    wait_ready();
    cif.cmd_valid = 1'b1;
    cif.cmd_op = 2'b01;
    @(posedge clk);
    repeat (6) @(negedge clk);
    cif.cmd_valid = 1'b0;
    chk("abort_em_on", 32'(control_em), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_em", 32'(control_em), 0);
    chk("abort_arm", 32'(arm_down), 0);
    chk("abort_hold", 32'(holding), 0);
    chk("abort_ready", 32'(cif.cmd_ready), 1);
    chk("abort_done", 32'(cif.done), 0);
    chk("abort_busy", 32'(busy), 0);
    repeat (20) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
